// File: rtl/bus_demux.sv
// Registered 1-to-2 byte demultiplexer: steers a producer's byte to out1 (con=0) or out2 (con=1),
// each output backed by a one-entry valid/ready holding register and a modulo-256 transfer counter.
module bus_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             con,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic             out1_valid,
  output logic             out2_valid,
  input  logic             out1_ready,
  input  logic             out2_ready,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2
);

  logic             r_v1;
  logic             r_v2;
  logic [WIDTH-1:0] r_d1;
  logic [WIDTH-1:0] r_d2;
  logic [7:0]       r_c1;
  logic [7:0]       r_c2;

  logic             w_in_ready;
  logic             w_xfer;
  logic             w_load1;
  logic             w_load2;

  // Ready depends only on the selected slot: empty, or being drained this edge.
  always_comb begin
    w_in_ready = 1'b0;
    w_xfer     = 1'b0;
    w_load1    = 1'b0;
    w_load2    = 1'b0;
    if (con) begin
      w_in_ready = !r_v2 || out2_ready;
    end else begin
      w_in_ready = !r_v1 || out1_ready;
    end
    w_xfer  = in_valid && w_in_ready;
    w_load1 = w_xfer && !con;
    w_load2 = w_xfer && con;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_d1 <= '0;
      r_d2 <= '0;
      r_c1 <= '0;
      r_c2 <= '0;
    end else begin
      // Load wins over drain so a simultaneous drain+fill keeps valid high.
      if (w_load1) begin
        r_d1 <= in_data;
        r_v1 <= 1'b1;
        r_c1 <= r_c1 + 8'd1;
      end else if (r_v1 && out1_ready) begin
        r_v1 <= 1'b0;
      end

      if (w_load2) begin
        r_d2 <= in_data;
        r_v2 <= 1'b1;
        r_c2 <= r_c2 + 8'd1;
      end else if (r_v2 && out2_ready) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out1_data  = r_d1;
  assign out2_data  = r_d2;
  assign out1_valid = r_v1;
  assign out2_valid = r_v2;
  assign cnt1       = r_c1;
  assign cnt2       = r_c2;

endmodule

// File: doc/bus_demux.md
# bus_demux

Registered 1-to-2 demultiplexer for the 8-bit datapath. It steers a byte from a single producer to one of two consumers, selected by `con`, so it is the distribution counterpart of the 2:1 datapath mux. Each output has a one-entry holding register with a valid/ready handshake, so a stalled consumer never corrupts or drops data. It sits between the ALU/bus-result stage and two destination units, such as the register file and the memory write port. Per-output transfer counters support debug and verification.

## Interface
- `WIDTH`, default 8: data width of input and both outputs.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_data`  in  WIDTH  byte offered by the producer.
- `con`  in  1  destination select; 0 routes to `out1`, 1 routes to `out2`.
- `in_valid`  in  1  producer has a byte.
- `in_ready`  out  1  block accepts the byte this cycle.
- `out1_data`, `out2_data`  out  WIDTH  held bytes.
- `out1_valid`, `out2_valid`  out  1  holding register is full.
- `out1_ready`, `out2_ready`  in  1  consumer takes the held byte this cycle.
- `cnt1`, `cnt2`  out  8  count of bytes accepted for each output, modulo 256.

## Operation
- Input handshake: a byte transfers when `in_valid && in_ready` is true at a rising edge of `clk`.
- `in_ready` is combinational from `con` and the selected output only:
  - `con=0`: `in_ready = !out1_valid || out1_ready`
  - `con=1`: `in_ready = !out2_valid || out2_ready`
  - `in_ready` has no dependence on `in_valid`.
- `con` is sampled only at the handshake edge. It may change freely while `in_valid` is low or while the block is stalled.
- Output handshake, per output X:
  - The held byte leaves when `outX_valid && outX_ready` is true at a rising edge.
  - While `outX_valid=1` and `outX_ready=0`, `outX_data` is held stable.
- Holding register X, next-state rules in priority order:
  1. Load, when an input transfer targets X: `outX_data <= in_data`, `outX_valid <= 1`. This case applies even if X drains in the same cycle (simultaneous drain+fill), so valid stays high with no bubble.
  2. Drain only: `outX_valid <= 0`; `outX_data` keeps its last value.
  3. Otherwise, hold.
- The non-selected output is never affected by an input transfer.
- Counters: `cntX` increments by 1 on each input transfer that targets X. It wraps from 255 to 0 with no flag.
- No reordering across outputs is possible or required. Each output delivers its own bytes in acceptance order.
- Reset (`rst_n=0` at an edge), including mid-operation:
  - `out1_valid`, `out2_valid` = 0.
  - `out1_data`, `out2_data` = 0.
  - `cnt1`, `cnt2` = 0.
  - Held bytes are discarded.
  - While reset is asserted, `in_ready` follows the combinational rule from the reset-state registers, so it is 1 after the first reset edge. No transfer is recorded on a cycle where `rst_n=0`; reset has priority over load and drain.

## Timing
- Latency: a byte accepted at edge N is visible on `outX_data` with `outX_valid=1` immediately after edge N. It can be consumed at edge N+1 at the earliest.
- Throughput: 1 byte per cycle into a single output when its consumer holds ready=1. Alternating `con` also gives 1 byte per cycle.
- Combinational paths are limited to `con`/`outX_ready` → `in_ready`. There is no path from `in_data` or `in_valid` to any output.
- Output data, valid and counters are registered. They change only at rising edges of `clk`.

## Test plan
- Reset check: hold `rst_n=0` for 2 cycles, then release. Both valids, both data outputs and both counters must read 0, and `in_ready` must read 1.
- Routing:
  - Send 0xA5 with `con=0`, then 0x3C with `con=1`, with both readies high. `out1_data` must show 0xA5 one cycle after the first edge, and `out2_data` must show 0x3C one cycle after the second.
  - Afterwards `cnt1=1` and `cnt2=1`.
- Backpressure:
  - Hold `out1_ready=0`, then send 0x11 followed by 0x22 to `out1`. 0x11 must be held, and `in_ready` must drop to 0 while `con=0`.
  - Switching to `con=1` must raise `in_ready`, and 0x33 must be accepted into `out2` while 0x11 stays held.
- Simultaneous drain+fill: stream 0x01–0x10 to `out1` with `out1_ready=1`. `out1_valid` must stay high every cycle and the data must appear in order 0x01…0x10 with no gaps.
- Counter wrap: send 257 bytes to `out2`. `cnt2` must read 1 and `cnt1` must read 0.
- Reset mid-operation: with `out1_valid=1` holding 0x77 and `cnt1=5`, assert `rst_n=0` for one edge while `in_valid=1`. `out1_valid` must become 0, `out1_data` 0x00 and `cnt1` 0, and no byte may be accepted on that edge.
